// File: rtl/alu_pkg.sv
// Shared ALU types for the pipelined add/sub path: result flag struct,
// add/sub opcode and the elaboration-time geometry check.
package alu_pkg;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    typedef enum logic [0:0] {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // WIDTH must split into whole CHUNK-bit slices, and a slice needs at least one bit.
    function automatic bit addsub_cfg_ok(input int width, input int chunk);
        bit ok_s;
        if (chunk < 1) begin
            ok_s = 1'b0;
        end else begin
            ok_s = ((width % chunk) == 0);
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Handshake/operand/result bundle for pipe_addsub.
// The saturation request in_sat exists only when ADDSUB_SAT_EN is defined.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
`ifdef ADDSUB_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_c;
    logic             out_v;
    logic             out_z;
    logic             out_n;

`ifdef ADDSUB_SAT_EN
    modport master (
        output in_valid, in_a, in_b, in_sub, in_sat, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_sat, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_v, out_z, out_n
    );
`endif
endinterface

// File: rtl/pipe_addsub_cla_slice.sv
// cla_slice: combinational CHUNK-bit carry-lookahead adder slice.
// Every internal carry is a flat sum of generate terms gated by the
// propagate run above them, so no carry ripples through the slice.
module cla_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK-1:0] g_s;
    logic [CHUNK-1:0] p_s;
    logic [CHUNK:0]   c_s;
    logic             carry_s;
    logic             prod_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
    always_comb begin
        c_s     = '0;
        carry_s = 1'b0;
        prod_s  = 1'b0;
        c_s[0]  = ci;
        for (int i = 0; i < CHUNK; i++) begin
            carry_s = g_s[i];
            prod_s  = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry_s = carry_s | (prod_s & g_s[j]);
                prod_s  = prod_s & p_s[j];
            end
            c_s[i+1] = carry_s | (prod_s & ci);
        end
    end

    assign s  = p_s ^ c_s[CHUNK-1:0];
    assign co = c_s[CHUNK];

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined CLA adder/subtractor, WIDTH/CHUNK stages, one
// slice per stage with the carry registered between slices. Operands
// skew down the pipe beside the partial sum. Whole-pipe advance on
// adv = !out_valid || out_ready; in_ready is that same enable.
// Optional feature macro: ADDSUB_SAT_EN (saturate on signed overflow when in_sat).
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input logic         clk,
    input logic         rst,
    pipe_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (!addsub_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_bad
        $error("pipe_addsub: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
    end

    logic                         adv_s;
    op_e                          op_s;
    logic [WIDTH-1:0]             b_eff_s;

    // Stage k register holds the op waiting for slice k.
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0]            cy_q, cy_d;
`ifdef ADDSUB_SAT_EN
    logic [STAGES-1:0]            sat_q, sat_d;
`endif

    logic [STAGES-1:0][CHUNK-1:0] slice_s_s;
    logic [STAGES-1:0]            slice_co_s;

    logic [WIDTH-1:0]             fin_sum_s;
    logic [WIDTH-1:0]             res_sum_s;
    logic                         fin_v_s;
    flags_t                       fin_flags_s;

    logic                         out_valid_q, out_valid_d;
    logic [WIDTH-1:0]             out_sum_q, out_sum_d;
    flags_t                       flags_q, flags_d;

    // Lower slices of the skew registers are dead by the last stage; fold them into one sink.
    logic                         unused_skew_s;
    assign unused_skew_s = ^{a_q, b_q, sum_q};

    assign adv_s        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv_s;
    assign op_s         = bus.in_sub ? OP_SUB : OP_ADD;
    assign b_eff_s      = (op_s == OP_SUB) ? ~bus.in_b : bus.in_b;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a  (a_q[k][k*CHUNK +: CHUNK]),
            .b  (b_q[k][k*CHUNK +: CHUNK]),
            .ci (cy_q[k]),
            .s  (slice_s_s[k]),
            .co (slice_co_s[k])
        );
    end

    // Next stage contents: shift every stage down one on advance, hold otherwise.
    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        cy_d  = cy_q;
`ifdef ADDSUB_SAT_EN
        sat_d = sat_q;
`endif
        if (adv_s) begin
            vld_d[0] = bus.in_valid;
            a_d[0]   = bus.in_a;
            b_d[0]   = b_eff_s;
            sum_d[0] = '0;
            cy_d[0]  = (op_s == OP_SUB);
`ifdef ADDSUB_SAT_EN
            sat_d[0] = bus.in_sat;
`endif
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                cy_d[k]  = slice_co_s[k-1];
                sum_d[k] = sum_q[k-1];
                sum_d[k][(k-1)*CHUNK +: CHUNK] = slice_s_s[k-1];
`ifdef ADDSUB_SAT_EN
                sat_d[k] = sat_q[k-1];
`endif
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Final stage: complete the sum, derive overflow, optionally saturate, then flags.
    always_comb begin
        fin_sum_s = sum_q[LAST];
        fin_sum_s[LAST*CHUNK +: CHUNK] = slice_s_s[LAST];
        fin_v_s   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                    (fin_sum_s[WIDTH-1] != a_q[LAST][WIDTH-1]);
        res_sum_s = fin_sum_s;
`ifdef ADDSUB_SAT_EN
        if (sat_q[LAST] && fin_v_s) begin
            if (a_q[LAST][WIDTH-1]) begin
                res_sum_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res_sum_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res_sum_s = fin_sum_s;
        end
`endif
        fin_flags_s.c = slice_co_s[LAST];
        fin_flags_s.v = fin_v_s;
        fin_flags_s.z = (res_sum_s == {WIDTH{1'b0}});
        fin_flags_s.n = res_sum_s[WIDTH-1];
    end

    // Output register: load on advance; data only changes when a real result arrives.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        flags_d     = flags_q;
        if (adv_s) begin
            out_valid_d = vld_q[LAST];
            if (vld_q[LAST]) begin
                out_sum_d = res_sum_s;
                flags_d   = fin_flags_s;
            end else begin
                out_sum_d = out_sum_q;
                flags_d   = flags_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage and output registers; reset drops every in-flight op and clears results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cy_q        <= '0;
`ifdef ADDSUB_SAT_EN
            sat_q       <= '0;
`endif
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            flags_q     <= '0;
        end else begin
            vld_q       <= vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cy_q        <= cy_d;
`ifdef ADDSUB_SAT_EN
            sat_q       <= sat_d;
`endif
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_c     = flags_q.c;
    assign bus.out_v     = flags_q.v;
    assign bus.out_z     = flags_q.z;
    assign bus.out_n     = flags_q.n;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: a 32/16 instance with a scoreboard
// plus a 64/16 instance for the width check. Honours ADDSUB_SAT_EN.
module tb_pipe_addsub;
    localparam int W   = 32;
    localparam int CW  = 16;
    localparam int W64 = 64;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb[$];
    exp_t got_r;
    exp_t exp_r;
    logic sat_sink;

    pipe_addsub_if #(.WIDTH(W))   bus   ();
    pipe_addsub_if #(.WIDTH(W64)) bus64 ();

    pipe_addsub #(.WIDTH(W),   .CHUNK(CW)) dut   (.clk(clk), .rst(rst), .bus(bus));
    pipe_addsub #(.WIDTH(W64), .CHUNK(CW)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed arithmetic for overflow, unsigned compare for carry/borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic sat);
        exp_t       e;
        longint     sa, sbv, res, max_v, min_v;
        logic [W:0] us;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        res   = sub ? (sa - sbv) : (sa + sbv);
        max_v = (longint'(1) <<< (W - 1)) - 1;
        min_v = -(longint'(1) <<< (W - 1));
        e.v   = (res > max_v) || (res < min_v);
        us    = {1'b0, a} + {1'b0, b};
        e.c   = sub ? (a >= b) : us[W];
        e.sum = sub ? (a - b) : (a + b);
        if (sat && e.v) begin
            e.sum = (res < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        e.z = (e.sum == '0);
        e.n = e.sum[W-1];
        return e;
    endfunction

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic sat);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
`ifdef ADDSUB_SAT_EN
        bus.in_sat   = sat;
`else
        sat_sink     = sat;
`endif
    endtask

    // Scoreboard monitor: sample mid-low-phase, pop/compare on output transfer, push on accept.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                got_r = {bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: unexpected result sum=%h cvzn=%b", got_r.sum, got_r[3:0]);
                end else begin
                    exp_r = sb.pop_front();
                    if (got_r !== exp_r) begin
                        errors++;
                        $display("FAIL sb_result: got sum=%h cvzn=%b, expected sum=%h cvzn=%b",
                                 got_r.sum, got_r[3:0], exp_r.sum, exp_r[3:0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
`ifdef ADDSUB_SAT_EN
                sb.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_sat));
`else
                sb.push_back(model(bus.in_a, bus.in_b, bus.in_sub, 1'b0));
`endif
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        set_op('0, '0, 1'b0, 1'b0);
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_a      = '0;
        bus64.in_b      = '0;
        bus64.in_sub    = 1'b0;
`ifdef ADDSUB_SAT_EN
        bus64.in_sat    = 1'b0;
`endif
        bus64.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== {1'b0, 32'h0, 4'b0}) begin
            errors++;
            $display("FAIL reset_held: got valid=%b sum=%h, expected valid=0 sum=0", bus.out_valid, bus.out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus64.out_valid, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.out_valid, bus64.out_valid, bus.out_c, bus.out_v, bus.out_z, bus.out_n});
        end
    endtask

    task automatic test_carry();
        @(negedge clk);
        set_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL carry_in_ready: got %b expected 1", bus.in_ready);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.out_valid !== (i == 3)) begin
                errors++;
                $display("FAIL carry_latency: edge %0d got valid=%b expected %b", i, bus.out_valid, (i == 3));
            end
        end
        checks++;
        if ({bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== {32'h00010000, 4'b0000}) begin
            errors++;
            $display("FAIL carry_value: got sum=%h cvzn=%b%b%b%b expected 00010000 0000",
                     bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_sum;
        logic         exp_n;
`ifdef ADDSUB_SAT_EN
        exp_sum = 32'h7FFFFFFF;
        exp_n   = 1'b0;
`else
        exp_sum = 32'h80000000;
        exp_n   = 1'b1;
`endif
        @(negedge clk);
        set_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !==
            {1'b1, exp_sum, 1'b0, 1'b1, 1'b0, exp_n}) begin
            errors++;
            $display("FAIL overflow: got valid=%b sum=%h cvzn=%b%b%b%b expected sum=%h v=1 n=%b",
                     bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n, exp_sum, exp_n);
        end
    endtask

    task automatic test_sub_zero();
        @(negedge clk);
        set_op(32'd5, 32'd5, 1'b1, 1'b0);
        @(negedge clk);
        set_op(32'd0, 32'd1, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== {1'b1, 32'h0, 4'b1010}) begin
            errors++;
            $display("FAIL sub_zero: got sum=%h cvzn=%b%b%b%b expected 00000000 1010",
                     bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== {1'b1, 32'hFFFFFFFF, 4'b0001}) begin
            errors++;
            $display("FAIL sub_borrow: got sum=%h cvzn=%b%b%b%b expected ffffffff 0001",
                     bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ops_a [4];
        logic [W-1:0] ops_b [4];
        logic [W+3:0] held;
        int           idx;
        int           n_out;
        idx   = 0;
        n_out = 0;
        held  = '0;
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = $urandom();
            ops_b[i] = $urandom();
        end
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            if (idx < 4) begin
                set_op(ops_a[idx], ops_b[idx], (idx % 2) == 1, 1'b0);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == 3) begin
                held = {bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n};
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_valid: got %b expected 1 at stall start", bus.out_valid);
                end
            end
            if (cyc >= 3 && cyc <= 5) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: cycle %0d got %b expected 0", cyc, bus.in_ready);
                end
                checks++;
                if ({bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got %h expected %h", cyc,
                             {bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n}, held);
                end
            end
            if (bus.out_valid && bus.out_ready) n_out++;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        checks++;
        if (n_out !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d results expected 4", n_out);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        @(negedge clk);
        set_op(32'h33333333, 32'h44444444, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum} !== {1'b1, 32'h33333333}) begin
            errors++;
            $display("FAIL rst_pre: got valid=%b sum=%h expected 1 33333333", bus.out_valid, bus.out_sum);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_c, bus.out_v, bus.out_z, bus.out_n} !== {1'b0, 32'h0, 4'b0}) begin
            errors++;
            $display("FAIL rst_async: got valid=%b sum=%h expected 0 00000000", bus.out_valid, bus.out_sum);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale: cycle %0d got valid=%b expected 0", i, bus.out_valid);
            end
        end
        @(negedge clk);
        set_op(32'd3, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_early: got valid=%b expected 0", bus.out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sum} !== {1'b1, 32'd7}) begin
            errors++;
            $display("FAIL rst_next: got valid=%b sum=%h expected 1 00000007", bus.out_valid, bus.out_sum);
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        bus64.in_valid = 1'b1;
        bus64.in_a     = 64'hFFFFFFFFFFFFFFFF;
        bus64.in_b     = 64'h1;
        bus64.in_sub   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus64.in_valid = 1'b0;
            #1;
            checks++;
            if (bus64.out_valid !== (i == 5)) begin
                errors++;
                $display("FAIL wide_latency: edge %0d got valid=%b expected %b", i, bus64.out_valid, (i == 5));
            end
        end
        checks++;
        if ({bus64.out_sum, bus64.out_c, bus64.out_v, bus64.out_z, bus64.out_n} !== {64'h0, 4'b1010}) begin
            errors++;
            $display("FAIL wide_value: got sum=%h cvzn=%b%b%b%b expected 0 1010",
                     bus64.out_sum, bus64.out_c, bus64.out_v, bus64.out_z, bus64.out_n);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pick [8];
        pick[0] = 32'h00000000;
        pick[1] = 32'h00000001;
        pick[2] = 32'hFFFFFFFF;
        pick[3] = 32'h7FFFFFFF;
        pick[4] = 32'h80000000;
        pick[5] = 32'h0000FFFF;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            pick[6] = $urandom();
            pick[7] = $urandom();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            set_op(pick[$urandom_range(0, 7)], pick[$urandom_range(0, 7)],
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            bus.in_valid = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        sat_sink = 1'b0;
        test_reset();
        test_carry();
        test_overflow();
        test_sub_zero();
        test_backpressure();
        test_reset_midflight();
        test_wide();
        test_random();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake and a full flag set. The datapath is split into CHUNK-bit slices, and the carry is registered between slices, so WIDTH scales without lengthening the critical path. It sits between the ALU operand-select stage and the result-writeback stage, and replaces the fixed 32-bit single-cycle add/sub path.

## Interface
Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 16: bits summed per pipeline stage by one CLA slice.
- STAGES = WIDTH/CHUNK: local parameter, not overridable; equals the latency in cycles.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operands presented.
- in_ready, output, 1: the block accepts an operation this cycle.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_sub, input, 1: 0 computes A+B; 1 computes A−B (B inverted, carry-in 1).
- in_sat, input, 1: saturate on signed overflow. Present only when ADDSUB_SAT_EN is defined.
- out_valid, output, 1: result available.
- out_ready, input, 1: the consumer accepts the result.
- out_sum, output, WIDTH: result.
- out_c, output, 1: carry out of the MSB. For subtraction, 1 means no borrow.
- out_v, output, 1: signed overflow.
- out_z, output, 1: out_sum == 0.
- out_n, output, 1: out_sum[WIDTH-1].

## Operation
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- B' = in_sub ? ~in_b : in_b; carry-in = in_sub.
- Stage k (0..STAGES-1) sums slice k of A and B' with the registered carry from stage k−1.
  - Stage 0 uses the carry-in.
  - Completed lower slices and not-yet-summed upper slices of A/B' travel alongside in skew registers.
- Overflow: v = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), computed in the final stage.
- out_c is the carry out of the last slice.
- out_z and out_n are derived from the final out_sum, including after saturation.
- Every stage holds one valid bit. The pipeline advances as a whole when adv = !out_valid || out_ready.
- in_ready = adv. This is a combinational path from out_ready; no skid buffer.
- There is no FSM. Control is STAGES valid bits plus the global advance enable.
- Ordering is strict FIFO, with no reordering and no drops.

## Timing
- Latency: an operation accepted at edge t produces out_valid = 1 after edge t+STAGES, provided no stall occurs.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, all stage registers, out_sum and the flags hold stable. in_ready = 0.
- Bubbles: when in_valid = 0, a bubble enters the pipeline. Bubbles compress in the output stage only when !out_valid.
- Simultaneous accept and output handshake in the same cycle is legal; both transfer.
- Reset (async assert, released synchronously by the system):
  - All valid bits and out_valid go to 0 immediately.
  - out_sum = 0; out_c, out_v, out_z, out_n = 0.
  - in_ready is 1 whenever rst = 0 and the pipeline is empty.
- Reset mid-operation discards all in-flight operations. No result for them ever appears.
- Data registers need no reset other than the output registers, but resetting them is permitted.

## Configuration
- ADDSUB_SAT_EN defined:
  - Port in_sat exists.
  - When in_sat = 1 and v = 1, out_sum = A[MSB] ? {1'b1, {WIDTH-1{1'b0}}} : {1'b0, {WIDTH-1{1'b1}}}.
  - out_v still reports 1. out_c is unchanged.
  - in_sat is carried down the pipeline with its operation.
- ADDSUB_SAT_EN undefined:
  - in_sat is absent.
  - The result always wraps modulo 2^WIDTH.

## Structure
- Shared package alu_pkg holds:
  - the typedef of the flag struct {c, v, z, n};
  - the typedef of the add/sub opcode enum {OP_ADD, OP_SUB};
  - an elaboration-time check function requiring WIDTH % CHUNK == 0 and CHUNK >= 1.
- Sub-module cla_slice (parameter CHUNK, combinational): generate/propagate lookahead over CHUNK bits, taking the carry-in and producing the sum and carry-out. pipe_addsub instantiates STAGES copies.

## Test plan
WIDTH=32, CHUNK=16 (latency 2) unless noted:
- Carry across slices: add 0x0000FFFF + 0x00000001 → 2 cycles later out_sum = 0x00010000, c=0, v=0, z=0, n=0.
- Overflow: add 0x7FFFFFFF + 1 → 0x80000000, v=1, n=1. With ADDSUB_SAT_EN and in_sat=1 → 0x7FFFFFFF, v=1, n=0.
- Subtract to zero: 5 − 5 → 0x00000000, z=1, c=1, v=0. Then 0 − 1 → 0xFFFFFFFF, c=0, n=1.
- Backpressure: 4 back-to-back ops with out_ready=0 for 3 cycles mid-stream → all 4 emerge in order, no duplication, out_sum stable while stalled, in_ready=0 during the stall.
- Reset mid-flight: assert rst with 2 ops in flight → out_valid=0 asynchronously and all outputs 0; after release no stale result appears; the next op completes in 2 cycles.
- Width generalisation: WIDTH=64, CHUNK=16, 0xFFFFFFFFFFFFFFFF + 1 → after 4 cycles out_sum = 0, c=1, z=1, v=0.
